win_scan_seq: RTL and testbench

WIN_SCAN_SEQ -- requirements
Module: win_scan_seq

---
 rtl/score4_pkg.sv | 34 +++
 rtl/line_check.sv | 65 ++++++
 rtl/win_scan_seq.sv | 213 +++++++++++++++++++++
 tb/tb_win_scan_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score4_pkg.sv
// Shared types for the board scanner: cell encoding, one-hot line
// directions, and the scan FSM states.
package score4_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PLAYER_A = 2'd1,
    PLAYER_B = 2'd2,
    INVALID  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_ROW = 4'b0001;  // (i, j+k)
  localparam dir_t DIR_COL = 4'b0010;  // (i+k, j)
  localparam dir_t DIR_LR  = 4'b0100;  // (i+k, j+k)
  localparam dir_t DIR_RL  = 4'b1000;  // (i+k, j-k)

  // Reduce a multi-hit vector to one direction: row > column > l-to-r > r-to-l.
  function automatic dir_t dir_pick(input logic [3:0] hit);
    if (hit[0])      return DIR_ROW;
    else if (hit[1]) return DIR_COL;
    else if (hit[2]) return DIR_LR;
    else if (hit[3]) return DIR_RL;
    else             return 4'b0000;
  endfunction

endpackage

// File: rtl/line_check.sv
// Combinational line detector: from one anchor cell, tests the four
// directions for WIN_LEN equal player cells that all lie on the board.
// Board packing: cell (i,j) occupies bits [(i*COLS+j)*2 +: 2].
module line_check
  import score4_pkg::*;
#(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic [ROWS*COLS*2-1:0]   board,
  input  logic [$clog2(ROWS)-1:0]  ai,
  input  logic [$clog2(COLS)-1:0]  aj,
  output logic [3:0]               hit,
  output logic [1:0]               val
);

  localparam int BW = $clog2(ROWS*COLS*2);

  function automatic logic [1:0] cell_at(input logic [ROWS*COLS*2-1:0] b,
                                         input int r, input int c);
    return b[BW'((r*COLS + c)*2) +: 2];
  endfunction

  // Walk every direction from the anchor; out-of-bounds lines are rejected
  // before any cell beyond the board edge is looked at.
  always_comb begin
    int   r0;
    int   c0;
    int   dr;
    int   dc;
    int   r_end;
    int   c_end;
    logic ok;
    r0    = int'(ai);
    c0    = int'(aj);
    dr    = 0;
    dc    = 0;
    r_end = 0;
    c_end = 0;
    ok    = 1'b0;
    hit   = 4'b0000;
    val   = cell_at(board, r0, c0);
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dr = 0; dc = 1;  end
        1:       begin dr = 1; dc = 0;  end
        2:       begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      r_end = r0 + (WIN_LEN-1)*dr;
      c_end = c0 + (WIN_LEN-1)*dc;
      ok = (val == PLAYER_A || val == PLAYER_B) &&
           (r0 < ROWS) && (c0 < COLS) &&
           (r_end < ROWS) && (c_end >= 0) && (c_end < COLS);
      for (int k = 1; k < WIN_LEN; k++) begin
        if (ok) begin
          if (cell_at(board, r0 + k*dr, c0 + k*dc) != val) ok = 1'b0;
        end
      end
      hit[d] = ok;
    end
  end

endmodule

// File: rtl/win_scan_seq.sv
// Sequential board scanner: snapshots a panel, walks anchors in row-major
// order one per cycle, and reports the first winning line, a draw, or
// the presence of invalid cells.
//
// Handshake: start is a request sampled on the rising edge and accepted
// only while busy=0 (IDLE or DONE); the accepting edge snapshots panel and
// clears every result. done is a one-cycle pulse, coincident with busy
// falling, and results hold until the next accepted start.
module win_scan_seq
  import score4_pkg::*;
#(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROWS*COLS*2-1:0]   panel,
  output logic                     busy,
  output logic                     done,
  output logic                     win_a,
  output logic                     win_b,
  output logic [3:0]               dir,
  output logic [$clog2(ROWS)-1:0]  i_win,
  output logic [$clog2(COLS)-1:0]  j_win,
  output logic                     draw,
  output logic                     err,
  output state_t                   state_dbg
);

  localparam int N  = ROWS*COLS;
  localparam int BW = $clog2(N*2);
  localparam int IW = $clog2(ROWS);
  localparam int JW = $clog2(COLS);
  localparam logic [IW-1:0] I_LAST = IW'(ROWS-1);
  localparam logic [JW-1:0] J_LAST = JW'(COLS-1);

  state_t          state_q, state_d;
  logic [N*2-1:0]  snap_q, snap_d;
  logic [IW-1:0]   ai_q, ai_d;
  logic [JW-1:0]   aj_q, aj_d;
  // Registered result of the previous anchor's evaluation; the decision to
  // stop is taken one cycle after evaluation.
  logic [3:0]      chk_hit_q, chk_hit_d;
  logic [1:0]      chk_val_q, chk_val_d;
  logic [IW-1:0]   chk_i_q, chk_i_d;
  logic [JW-1:0]   chk_j_q, chk_j_d;
  logic            chk_last_q, chk_last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            win_a_q, win_a_d;
  logic            win_b_q, win_b_d;
  dir_t            dir_q, dir_d;
  logic [IW-1:0]   i_win_q, i_win_d;
  logic [JW-1:0]   j_win_q, j_win_d;
  logic            draw_q, draw_d;
  logic            err_q, err_d;

  logic [3:0]      lc_hit;
  logic [1:0]      lc_val;
  logic            any_inv;
  logic            all_full;

  line_check #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_LEN (WIN_LEN)
  ) u_line_check (
    .board (snap_q),
    .ai    (ai_q),
    .aj    (aj_q),
    .hit   (lc_hit),
    .val   (lc_val)
  );

  // Whole-snapshot summaries, independent of where the scan stops.
  always_comb begin
    any_inv  = 1'b0;
    all_full = 1'b1;
    for (int n = 0; n < N; n++) begin
      if (snap_q[BW'(n*2) +: 2] == INVALID) any_inv  = 1'b1;
      if (snap_q[BW'(n*2) +: 2] == EMPTY)   all_full = 1'b0;
    end
  end

  // Next-state, anchor walk and result capture.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    ai_d       = ai_q;
    aj_d       = aj_q;
    chk_hit_d  = chk_hit_q;
    chk_val_d  = chk_val_q;
    chk_i_d    = chk_i_q;
    chk_j_d    = chk_j_q;
    chk_last_d = chk_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    win_a_d    = win_a_q;
    win_b_d    = win_b_q;
    dir_d      = dir_q;
    i_win_d    = i_win_q;
    j_win_d    = j_win_q;
    draw_d     = draw_q;
    err_d      = err_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d    = SCAN;
          snap_d     = panel;
          ai_d       = '0;
          aj_d       = '0;
          chk_hit_d  = 4'b0000;
          chk_last_d = 1'b0;
          busy_d     = 1'b1;
          win_a_d    = 1'b0;
          win_b_d    = 1'b0;
          dir_d      = 4'b0000;
          i_win_d    = '0;
          j_win_d    = '0;
          draw_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      SCAN: begin
        chk_hit_d  = lc_hit;
        chk_val_d  = lc_val;
        chk_i_d    = ai_q;
        chk_j_d    = aj_q;
        chk_last_d = (ai_q == I_LAST) && (aj_q == J_LAST);
        // The counter parks on the last anchor rather than wrapping.
        if (!((ai_q == I_LAST) && (aj_q == J_LAST))) begin
          if (aj_q == J_LAST) begin
            aj_d = '0;
            ai_d = ai_q + 1'b1;
          end else begin
            aj_d = aj_q + 1'b1;
          end
        end
        if ((|chk_hit_q) || chk_last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          win_a_d = (|chk_hit_q) && (chk_val_q == PLAYER_A);
          win_b_d = (|chk_hit_q) && (chk_val_q == PLAYER_B);
          dir_d   = dir_pick(chk_hit_q);
          i_win_d = (|chk_hit_q) ? chk_i_q : '0;
          j_win_d = (|chk_hit_q) ? chk_j_q : '0;
          err_d   = any_inv;
          draw_d  = !(|chk_hit_q) && all_full && !any_inv;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; rst wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      ai_q       <= '0;
      aj_q       <= '0;
      chk_hit_q  <= 4'b0000;
      chk_val_q  <= 2'b00;
      chk_i_q    <= '0;
      chk_j_q    <= '0;
      chk_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      win_a_q    <= 1'b0;
      win_b_q    <= 1'b0;
      dir_q      <= 4'b0000;
      i_win_q    <= '0;
      j_win_q    <= '0;
      draw_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      ai_q       <= ai_d;
      aj_q       <= aj_d;
      chk_hit_q  <= chk_hit_d;
      chk_val_q  <= chk_val_d;
      chk_i_q    <= chk_i_d;
      chk_j_q    <= chk_j_d;
      chk_last_q <= chk_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      win_a_q    <= win_a_d;
      win_b_q    <= win_b_d;
      dir_q      <= dir_d;
      i_win_q    <= i_win_d;
      j_win_q    <= j_win_d;
      draw_q     <= draw_d;
      err_q      <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_a     = win_a_q;
  assign win_b     = win_b_q;
  assign dir       = dir_q;
  assign i_win     = i_win_q;
  assign j_win     = j_win_q;
  assign draw      = draw_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_win_scan_seq.sv
// Directed bench for win_scan_seq: a table of hand-built boards with
// hand-computed latency/results, plus multi-cycle corner sequences and a
// second 8x8, WIN_LEN=5 instance.
module tb_win_scan_seq;
  import score4_pkg::*;

  localparam int R  = 6;
  localparam int C  = 7;
  localparam int P  = R*C*2;
  localparam int P2 = 8*8*2;
  localparam int NV = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (default geometry) ----------------
  logic         start = 1'b0;
  logic [P-1:0] panel = '0;
  logic         busy, done, win_a, win_b, draw, err;
  logic [3:0]   dir;
  logic [2:0]   i_win, j_win;
  state_t       state_dbg;

  win_scan_seq dut (
    .clk(clk), .rst(rst), .start(start), .panel(panel),
    .busy(busy), .done(done), .win_a(win_a), .win_b(win_b), .dir(dir),
    .i_win(i_win), .j_win(j_win), .draw(draw), .err(err),
    .state_dbg(state_dbg)
  );

  // ---------------- DUT (8x8, WIN_LEN 5) ----------------
  logic          start2 = 1'b0;
  logic [P2-1:0] panel2 = '0;
  logic          busy2, done2, win_a2, win_b2, draw2, err2;
  logic [3:0]    dir2;
  logic [2:0]    i_win2, j_win2;
  state_t        state_dbg2;

  win_scan_seq #(.ROWS(8), .COLS(8), .WIN_LEN(5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .panel(panel2),
    .busy(busy2), .done(done2), .win_a(win_a2), .win_b(win_b2), .dir(dir2),
    .i_win(i_win2), .j_win(j_win2), .draw(draw2), .err(err2),
    .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [13:0] exp_q[$];

  typedef struct {
    logic [P-1:0] panel;
    int           lat;
    logic [13:0]  res;
    string        name;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Result word: {win_a, win_b, dir[3:0], i_win[2:0], j_win[2:0], draw, err}
  function automatic logic [13:0] mk_res(input logic a, input logic b, input logic [3:0] d,
                                         input int i, input int j, input logic dr, input logic e);
    return {a, b, d, 3'(i), 3'(j), dr, e};
  endfunction

  function automatic logic [13:0] dut_res();
    return {win_a, win_b, dir, i_win, j_win, draw, err};
  endfunction

  function automatic logic [P-1:0] put(input logic [P-1:0] b, input int i, input int j,
                                       input logic [1:0] v);
    b[7'((i*C + j)*2) +: 2] = v;
    return b;
  endfunction

  // Full board, cell = A when ((j>>1)+i) is even: every run is at most 2 long.
  function automatic logic [P-1:0] mk_draw();
    logic [P-1:0] b;
    b = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        b = put(b, i, j, ((((j >> 1) + i) % 2) == 0) ? 2'd1 : 2'd2);
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_vec(input logic [P-1:0] p, input int exp_lat,
                         input logic [13:0] exp_res, input string nm);
    int lat;
    logic [13:0] e;
    exp_q.push_back(exp_res);
    @(negedge clk);
    panel = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({"accept_", nm}, {busy, done, dut_res()}, {1'b1, 1'b0, 14'd0});
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({"latency_", nm}, lat, exp_lat);
    e = exp_q.pop_front();
    chk({"result_", nm}, dut_res(), e);
    chk({"busy_at_done_", nm}, busy, 1'b0);
  endtask

  task automatic hold_check(input logic [13:0] exp_res, input string nm);
    @(posedge clk);
    #1;
    chk({"done_pulse_", nm}, done, 1'b0);
    chk({"hold_", nm}, dut_res(), exp_res);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [P-1:0]  b;
    logic [P2-1:0] b2;
    int            lat;
    int            done_cnt;

    // ---- vector table ----
    b = '0; for (int j = 1; j <= 4; j++) b = put(b, 2, j, 2'd1);
    vecs[0] = '{b, 17, mk_res(1, 0, 4'b0001, 2, 1, 0, 0), "row_a"};
    b = '0; for (int i = 0; i <= 3; i++) b = put(b, i, 6, 2'd2);
    vecs[1] = '{b, 8, mk_res(0, 1, 4'b0010, 0, 6, 0, 0), "col_b"};
    b = '0; for (int j = 3; j <= 6; j++) b = put(b, 0, j, 2'd1);
    for (int k = 1; k <= 3; k++) b = put(b, k, 3 - k, 2'd1);
    vecs[2] = '{b, 5, mk_res(1, 0, 4'b0001, 0, 3, 0, 0), "prio_row"};
    b = '0; for (int k = 0; k <= 3; k++) b = put(b, 2 + k, k, 2'd2);
    vecs[3] = '{b, 16, mk_res(0, 1, 4'b0100, 2, 0, 0, 0), "diag_lr"};
    b = '0; for (int k = 0; k <= 3; k++) b = put(b, 1 + k, 5 - k, 2'd1);
    vecs[4] = '{b, 14, mk_res(1, 0, 4'b1000, 1, 5, 0, 0), "diag_rl"};
    b = '0; for (int j = 3; j <= 6; j++) b = put(b, 5, j, 2'd1);
    vecs[5] = '{b, 40, mk_res(1, 0, 4'b0001, 5, 3, 0, 0), "last_row"};
    vecs[6] = '{mk_draw(), 43, mk_res(0, 0, 4'b0000, 0, 0, 1, 0), "draw"};
    vecs[7] = '{put(mk_draw(), 5, 6, 2'd3), 43, mk_res(0, 0, 4'b0000, 0, 0, 0, 1), "err_full"};
    b = '0; for (int j = 0; j <= 3; j++) b = put(b, 0, j, 2'd3);
    vecs[8] = '{b, 43, mk_res(0, 0, 4'b0000, 0, 0, 0, 1), "inv_line"};
    b = '0; for (int j = 4; j <= 6; j++) b = put(b, 0, j, 2'd1);
    for (int j = 0; j <= 2; j++) b = put(b, 1, j, 2'd1);
    b = put(b, 1, 3, 2'd2);
    vecs[9] = '{b, 43, mk_res(0, 0, 4'b0000, 0, 0, 0, 0), "short_run"};
    vecs[10] = '{'0, 43, mk_res(0, 0, 4'b0000, 0, 0, 0, 0), "empty"};
    b = '0; for (int j = 0; j <= 3; j++) b = put(b, 0, j, 2'd1);
    b = put(b, 5, 6, 2'd3);
    vecs[11] = '{b, 2, mk_res(1, 0, 4'b0001, 0, 0, 0, 1), "early_err"};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_results", dut_res(), 14'd0);
    chk("reset_state", state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;

    // ---- table ----
    for (int v = 0; v < NV; v++) begin
      run_vec(vecs[v].panel, vecs[v].lat, vecs[v].res, vecs[v].name);
      hold_check(vecs[v].res, vecs[v].name);
    end

    // ---- start accepted straight from DONE (back-to-back) ----
    run_vec(vecs[1].panel, vecs[1].lat, vecs[1].res, "b2b_first");
    run_vec(vecs[3].panel, vecs[3].lat, vecs[3].res, "b2b_second");
    hold_check(vecs[3].res, "b2b_second");

    // ---- start during SCAN ignored, snapshot unaffected by panel changes ----
    exp_q.push_back(vecs[0].res);
    @(negedge clk);
    panel = vecs[0].panel;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (n == 4) begin
        panel = vecs[1].panel;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("ignore_start_latency", lat, 17);
    chk("ignore_start_result", dut_res(), exp_q.pop_front());

    // ---- rst mid-scan: aborts, no done ----
    @(negedge clk);
    panel = mk_draw();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
    end
    chk("midscan_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midscan_busy_after_rst", busy, 1'b0);
    chk("midscan_state_after_rst", state_dbg, IDLE);
    done_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("midscan_no_done", done_cnt, 0);

    // ---- rst and start together: rst wins ----
    @(negedge clk);
    panel = vecs[0].panel;
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_prio_busy", busy, 1'b0);
    chk("rst_prio_state", state_dbg, IDLE);
    @(posedge clk);
    #1;
    chk("rst_prio_stays_idle", {busy, state_dbg}, {1'b0, IDLE});

    // ---- 8x8, WIN_LEN 5: l-to-r B from (3,3); a 4-long A row must not win ----
    b2 = '0;
    for (int k = 0; k < 5; k++) b2[7'(((3 + k)*8 + (3 + k))*2) +: 2] = 2'd2;
    for (int j = 0; j < 4; j++) b2[7'((0*8 + j)*2) +: 2] = 2'd1;
    @(negedge clk);
    panel2 = b2;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = n;
        break;
      end
    end
    chk("big_latency", lat, 29);
    chk("big_result", {win_a2, win_b2, dir2, i_win2, j_win2, draw2, err2},
        mk_res(0, 1, 4'b0100, 3, 3, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
